aes_round_seq: RTL and testbench

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

---
 rtl/aes_round_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_round_seq.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_seq.sv
// ---------------------------------------------------------------------------
// aes_round_seq
//   Sequences one full 128-bit AES round (forward or inverse) through an
//   external 32-bit AES functional unit, one column word at a time.
//
//   Forward round : ShiftRows -> SubBytes (4 ops) -> MixColumns (4 ops) -> ^key
//   Inverse round : InvShiftRows -> InvSubBytes (4 ops) -> ^key -> InvMixColumns (4 ops)
//   Final rounds skip the (Inv)MixColumns pass.
//   ShiftRows is applied while the request is loaded. It is a pure byte
//   permutation, so it commutes with the bytewise SubBytes that follows.
//
// Ports
//   g_clk, g_reset          clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_dec, req_last       inverse round select, final round (no mix)
//   req_state, req_rkey     128-bit state and round key (word c = column c,
//                           byte r of a word = row r)
//   rsp_valid/rsp_ready     response handshake, rsp_state = round result
//   fu_valid/fu_ready       functional unit operation handshake
//   fu_dec, fu_mix, fu_rs1  operation select (inverse, mix vs. sub), operand
//   fu_rd                   functional unit result word
// All outputs are driven directly from flops.
// ---------------------------------------------------------------------------
module aes_round_seq #(
  parameter bit DECRYPT_EN = 1'b1
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic         req_last,
  input  logic [127:0] req_state,
  input  logic [127:0] req_rkey,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state,
  output logic         fu_valid,
  output logic         fu_dec,
  output logic         fu_mix,
  output logic [31:0]  fu_rs1,
  input  logic         fu_ready,
  input  logic [31:0]  fu_rd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] MIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // new[r][c] = old[r][(c+r) mod 4]
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*c + 8*r +: 8] = s[32*((c + r) % 4) + 8*r +: 8];
      end
    end
    return o;
  endfunction

  // new[r][c] = old[r][(c-r) mod 4]
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[32*c + 8*r +: 8] = s[32*((c - r + 4) % 4) + 8*r +: 8];
      end
    end
    return o;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [127:0] w_q, w_d;
  logic [127:0] r_q, r_d;
  logic         dec_q, dec_d;
  logic         last_q, last_d;
  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         fu_valid_q, fu_valid_d;
  logic         fu_dec_q, fu_dec_d;
  logic         fu_mix_q, fu_mix_d;
  logic [31:0]  fu_rs1_q, fu_rs1_d;
  logic         fu_done_s;

  // fu_ready only counts while an operation is actually being offered
  assign fu_done_s = fu_valid_q & fu_ready;

  // Round sequencing: next state, column index, working state and key
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    r_d     = r_q;
    dec_d   = dec_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_valid & req_ready_q) begin
          dec_d  = req_dec & DECRYPT_EN;
          last_d = req_last;
          r_d    = req_rkey;
          if (req_dec & DECRYPT_EN) begin
            w_d = inv_shift_rows(req_state);
          end else begin
            w_d = shift_rows(req_state);
          end
          idx_d   = 2'd0;
          state_d = SUB;
        end else begin
          state_d = IDLE;
        end
      end
      SUB: begin
        if (fu_done_s) begin
          w_d[{idx_q, 5'b00000} +: 32] = fu_rd;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Inverse rounds add the key between InvSubBytes and InvMixColumns
            if (dec_q) begin
              w_d = w_d ^ r_q;
              if (last_q) begin
                state_d = DONE;
              end else begin
                state_d = MIX;
              end
            end else if (last_q) begin
              w_d     = w_d ^ r_q;
              state_d = DONE;
            end else begin
              state_d = MIX;
            end
          end else begin
            state_d = SUB;
          end
        end else begin
          state_d = SUB;
        end
      end
      MIX: begin
        if (fu_done_s) begin
          w_d[{idx_q, 5'b00000} +: 32] = fu_rd;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (dec_q) begin
              state_d = DONE;
            end else begin
              w_d     = w_d ^ r_q;
              state_d = DONE;
            end
          end else begin
            state_d = MIX;
          end
        end else begin
          state_d = MIX;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Output flops are loaded from the next-state values, so they line up with state_q
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    fu_valid_d  = (state_d == SUB) || (state_d == MIX);
    fu_mix_d    = (state_d == MIX);
    if (fu_valid_d) begin
      fu_dec_d = dec_d;
      fu_rs1_d = w_d[{idx_d, 5'b00000} +: 32];
    end else begin
      fu_dec_d = 1'b0;
      fu_rs1_d = 32'd0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      w_q         <= 128'd0;
      r_q         <= 128'd0;
      dec_q       <= 1'b0;
      last_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      fu_valid_q  <= 1'b0;
      fu_dec_q    <= 1'b0;
      fu_mix_q    <= 1'b0;
      fu_rs1_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      w_q         <= w_d;
      r_q         <= r_d;
      dec_q       <= dec_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      fu_valid_q  <= fu_valid_d;
      fu_dec_q    <= fu_dec_d;
      fu_mix_q    <= fu_mix_d;
      fu_rs1_q    <= fu_rs1_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_state = w_q;
  assign fu_valid  = fu_valid_q;
  assign fu_dec    = fu_dec_q;
  assign fu_mix    = fu_mix_q;
  assign fu_rs1    = fu_rs1_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_round_seq
//   Drives aes_round_seq with a behavioural 32-bit AES functional unit
//   (S-box derived from GF(2^8) inversion + affine map) and checks round
//   results against a scoreboard of reference-model values and a FIPS-197
//   known answer.
// ---------------------------------------------------------------------------
module tb_aes_round_seq;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_dec;
  logic         req_last;
  logic [127:0] req_state;
  logic [127:0] req_rkey;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_state;
  logic         fu_valid;
  logic         fu_dec;
  logic         fu_mix;
  logic [31:0]  fu_rs1;
  logic         fu_ready = 1'b0;
  logic [31:0]  fu_rd = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] exp_q [$];

  // Functional unit model controls and statistics
  int          max_delay = 0;
  logic        spurious  = 1'b0;
  int          txn_cnt = 0, dec_cnt = 0, mix_cnt = 0;
  int          stall_viol = 0, stall_cycles = 0;
  logic        fu_busy = 1'b0;
  int          fu_wait = 0;
  logic [31:0] hold_rs1 = 32'd0;
  logic        hold_mix = 1'b0, hold_dec = 1'b0;

  aes_round_seq dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_dec   (req_dec),
    .req_last  (req_last),
    .req_state (req_state),
    .req_rkey  (req_rkey),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_state (rsp_state),
    .fu_valid  (fu_valid),
    .fu_dec    (fu_dec),
    .fu_mix    (fu_mix),
    .fu_rs1    (fu_rs1),
    .fu_ready  (fu_ready),
    .fu_rd     (fu_rd)
  );

  always #5 g_clk = ~g_clk;

  // ---------------- GF(2^8) and AES reference pieces ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1b;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] mix_coef(input logic inv, input int k);
    logic [7:0] c;
    case (k)
      0: c = inv ? 8'h0e : 8'h02;
      1: c = inv ? 8'h0b : 8'h03;
      2: c = inv ? 8'h0d : 8'h01;
      default: c = inv ? 8'h09 : 8'h01;
    endcase
    return c;
  endfunction

  // Row r of the output column = sum_j coef[(j-r) mod 4] * a_j
  function automatic logic [31:0] mix_word(input logic [31:0] w, input logic inv);
    logic [31:0] o;
    logic [7:0]  acc;
    o = 32'd0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(mix_coef(inv, (j - r + 4) % 4), w[8*j +: 8]);
      o[8*r +: 8] = acc;
    end
    return o;
  endfunction

  function automatic logic [31:0] fu_model(input logic [31:0] w, input logic mix, input logic inv);
    logic [31:0] o;
    o = 32'd0;
    if (mix) begin
      o = mix_word(w, inv);
    end else begin
      for (int i = 0; i < 4; i++) o[8*i +: 8] = inv ? inv_sbox[w[8*i +: 8]] : sbox[w[8*i +: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] round_model(input logic [127:0] s, input logic [127:0] k,
                                               input logic dec, input logic last);
    logic [127:0] t;
    t = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[32*c + 8*r +: 8] = dec ? s[32*((c - r + 4) % 4) + 8*r +: 8] : s[32*((c + r) % 4) + 8*r +: 8];
    for (int i = 0; i < 16; i++) t[8*i +: 8] = dec ? inv_sbox[t[8*i +: 8]] : sbox[t[8*i +: 8]];
    if (dec) t = t ^ k;
    if (!last)
      for (int c = 0; c < 4; c++) t[32*c +: 32] = mix_word(t[32*c +: 32], dec);
    if (!dec) t = t ^ k;
    return t;
  endfunction

  // Byte 0 is written first in the hex text
  function automatic logic [127:0] le(input logic [127:0] be);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = be[127 - 8*i -: 8];
    return o;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = b;
      inv_sbox[b] = x[7:0];
    end
  endtask

  // Functional unit: answers after 0..max_delay wait cycles and watches operand stability
  always @(negedge g_clk) begin
    if (fu_valid === 1'b1) begin
      if (!fu_busy) begin
        fu_busy  = 1'b1;
        fu_wait  = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
        hold_rs1 = fu_rs1; hold_mix = fu_mix; hold_dec = fu_dec;
      end else begin
        stall_cycles++;
        if (fu_rs1 !== hold_rs1 || fu_mix !== hold_mix || fu_dec !== hold_dec) stall_viol++;
      end
      if (fu_wait == 0) begin
        fu_ready = 1'b1;
        fu_rd    = fu_model(fu_rs1, fu_mix, fu_dec);
        txn_cnt++;
        if (fu_dec) dec_cnt++;
        if (fu_mix) mix_cnt++;
        fu_busy  = 1'b0;
      end else begin
        fu_ready = 1'b0;
        fu_rd    = $urandom;
        fu_wait--;
      end
    end else begin
      fu_busy  = 1'b0;
      fu_ready = spurious;
      fu_rd    = $urandom;
    end
  end

  // Pushes the expected result, issues one request, and waits for rsp_valid.
  // lat = cycle (accept cycle = 0) in which rsp_valid is first seen.
  task automatic run_round(input logic [127:0] st, input logic [127:0] key,
                           input logic dec, input logic last, output int lat);
    int guard;
    exp_q.push_back(round_model(st, key, dec, last));
    @(negedge g_clk);
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin @(negedge g_clk); guard++; end
    req_valid = 1'b1; req_dec = dec; req_last = last; req_state = st; req_rkey = key;
    @(negedge g_clk);
    req_valid = 1'b0;
    req_state = {$urandom, $urandom, $urandom, $urandom};
    req_rkey  = {$urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge g_clk); lat++; end
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
  endtask

  logic [127:0] kat_in, kat_key, kat_out;

  task automatic test_reset();
    g_reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_dec = 1'b0; req_last = 1'b0;
    req_state = 128'd0; req_rkey = 128'd0;
    repeat (2) @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (fu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fu_valid: got %b expected 0", fu_valid); end
    n_checks++; if (rsp_state !== 128'd0) begin n_fail++; $display("FAIL reset_rsp_state: got %h expected 0", rsp_state); end
    n_checks++;
    if ({fu_mix, fu_dec, fu_rs1} !== 34'd0) begin
      n_fail++; $display("FAIL reset_fu_idle: got mix=%b dec=%b rs1=%h expected all 0", fu_mix, fu_dec, fu_rs1);
    end
  endtask

  task automatic test_forward();
    int lat, t0, m0, d0;
    logic [127:0] e;
    t0 = txn_cnt; m0 = mix_cnt; d0 = dec_cnt;
    run_round(kat_in, kat_key, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL fwd_latency: got %0d expected 9", lat); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL fwd_result: got %h expected %h", rsp_state, e); end
    n_checks++; if (rsp_state !== kat_out) begin n_fail++; $display("FAIL fwd_kat: got %h expected %h", rsp_state, kat_out); end
    n_checks++;
    if (txn_cnt - t0 != 8 || mix_cnt - m0 != 4 || dec_cnt - d0 != 0) begin
      n_fail++; $display("FAIL fwd_fu_ops: got txn=%0d mix=%0d dec=%0d expected 8 4 0", txn_cnt - t0, mix_cnt - m0, dec_cnt - d0);
    end
    retire();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_retire: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
    end
  endtask

  // A single inverse round does not undo a single forward round (the key add sits
  // between InvSubBytes and InvMixColumns), so the expectation is the model's.
  task automatic test_inverse();
    int lat, t0, d0;
    logic [127:0] e;
    t0 = txn_cnt; d0 = dec_cnt;
    run_round(kat_out, kat_key, 1'b1, 1'b0, lat);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL inv_latency: got %0d expected 9", lat); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL inv_result: got %h expected %h", rsp_state, e); end
    n_checks++;
    if (txn_cnt - t0 != 8 || dec_cnt - d0 != 8) begin
      n_fail++; $display("FAIL inv_fu_ops: got txn=%0d dec=%0d expected 8 8", txn_cnt - t0, dec_cnt - d0);
    end
    retire();
  endtask

  task automatic test_last();
    int lat, t0, m0;
    logic [127:0] e;
    t0 = txn_cnt; m0 = mix_cnt;
    run_round(kat_in, kat_key, 1'b0, 1'b1, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL last_latency: got %0d expected 5", lat); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL last_result: got %h expected %h", rsp_state, e); end
    n_checks++;
    if (txn_cnt - t0 != 4 || mix_cnt - m0 != 0) begin
      n_fail++; $display("FAIL last_fu_ops: got txn=%0d mix=%0d expected 4 0", txn_cnt - t0, mix_cnt - m0);
    end
    retire();
    run_round(kat_out, kat_key, 1'b1, 1'b1, lat);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL inv_last_latency: got %0d expected 5", lat); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL inv_last_result: got %h expected %h", rsp_state, e); end
    retire();
  endtask

  task automatic test_fu_stall();
    int lat, v0, s0;
    logic [127:0] e;
    v0 = stall_viol; s0 = stall_cycles;
    max_delay = 3; spurious = 1'b1;
    run_round(kat_in, kat_key, 1'b0, 1'b0, lat);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL stall_result: got %h expected %h", rsp_state, e); end
    n_checks++; if (rsp_state !== kat_out) begin n_fail++; $display("FAIL stall_kat: got %h expected %h", rsp_state, kat_out); end
    n_checks++; if (stall_viol - v0 != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", stall_viol - v0); end
    n_checks++;
    if (lat != 9 + (stall_cycles - s0)) begin
      n_fail++; $display("FAIL stall_latency: got %0d expected %0d", lat, 9 + (stall_cycles - s0));
    end
    retire();
    max_delay = 0;
  endtask

  // Response held for 5 cycles with a new request already waiting, then back-to-back
  task automatic test_back_to_back();
    int lat;
    logic [127:0] e, held, st2, k2, st3, k3;
    st2 = {$urandom, $urandom, $urandom, $urandom}; k2 = {$urandom, $urandom, $urandom, $urandom};
    st3 = {$urandom, $urandom, $urandom, $urandom}; k3 = {$urandom, $urandom, $urandom, $urandom};
    run_round(st2, k2, 1'b0, 1'b0, lat);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", rsp_state, e); end
    held = e;
    exp_q.push_back(round_model(st3, k3, 1'b1, 1'b0));
    req_valid = 1'b1; req_dec = 1'b1; req_last = 1'b0; req_state = st3; req_rkey = k3;
    for (int i = 0; i < 5; i++) begin
      @(negedge g_clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_state !== held || req_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: got valid=%b ready=%b state=%h expected 1 0 %h", i, rsp_valid, req_ready, rsp_state, held);
      end
    end
    retire();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready_after: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
    end
    @(negedge g_clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 200) begin @(negedge g_clk); lat++; end
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 9", lat); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", rsp_state, e); end
    retire();
    spurious = 1'b0;
  endtask

  task automatic test_reset_mid_mix();
    int lat;
    logic [127:0] e;
    @(negedge g_clk);
    req_valid = 1'b1; req_dec = 1'b0; req_last = 1'b0; req_state = kat_in; req_rkey = kat_key;
    @(negedge g_clk);
    req_valid = 1'b0;
    repeat (6) @(negedge g_clk);
    n_checks++;
    if (fu_valid !== 1'b1 || fu_mix !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_mix: got fu_valid=%b fu_mix=%b expected 1 1", fu_valid, fu_mix);
    end
    g_reset = 1'b1;
    @(negedge g_clk);
    g_reset = 1'b0;
    n_checks++;
    if (fu_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_state !== 128'd0) begin
      n_fail++; $display("FAIL mid_reset: got fu_valid=%b rsp_valid=%b req_ready=%b state=%h expected 0 0 1 0",
                         fu_valid, rsp_valid, req_ready, rsp_state);
    end
    run_round(kat_out, kat_key, 1'b0, 1'b0, lat);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 9", lat); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {128{1'bx}};
    n_checks++; if (rsp_state !== e) begin n_fail++; $display("FAIL post_reset_result: got %h expected %h", rsp_state, e); end
    retire();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    kat_in  = le(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    kat_key = le(128'ha0fafe1788542cb123a339392a6c7605);
    kat_out = le(128'ha49c7ff2689f352b6b5bea43026a5049);
    build_sbox();
    test_reset();
    test_forward();
    test_inverse();
    test_last();
    test_fu_stall();
    test_back_to_back();
    test_reset_mid_mix();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
